// File: rtl/decoder_scan.sv
// decoder_scan: registered binary-to-one-hot decoder with enable and prescaled autonomous scan
module decoder_scan #(
  parameter int SEL_W      = 2,
  parameter int DIV_W      = 16,
  parameter int ACTIVE_LOW = 0
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    en,
  input  logic                    mode,
  input  logic                    dir,
  input  logic [SEL_W-1:0]        x,
  input  logic [DIV_W-1:0]        div,
  output logic [(1<<SEL_W)-1:0]   y,
  output logic [SEL_W-1:0]        idx,
  output logic                    tick
);
  localparam int N = 1 << SEL_W;
  localparam logic [N-1:0] OFF = (ACTIVE_LOW != 0) ? {N{1'b1}} : {N{1'b0}};
  logic [SEL_W-1:0] idx_q, idx_d;
  logic [DIV_W-1:0] cnt_q, cnt_d;
  logic [N-1:0]     y_q, y_d;
  logic             tick_q, mode_q, run, step;
  // scanning only counts once mode has been 1 for a full edge, so a 0->1 change restarts the prescaler
  always_comb begin
    run   = en && mode && mode_q;
    step  = run && (cnt_q >= div);
    cnt_d = (run && !step) ? cnt_q + DIV_W'(1) : '0;
    idx_d = !en ? idx_q : !mode ? x : !step ? idx_q : dir ? idx_q - SEL_W'(1) : idx_q + SEL_W'(1);
    y_d   = en ? (OFF ^ (N'(1) << idx_d)) : OFF;
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      idx_q  <= '0;
      cnt_q  <= '0;
      tick_q <= 1'b0;
      mode_q <= 1'b0;
      y_q    <= OFF;
    end else begin
      idx_q  <= idx_d;
      cnt_q  <= cnt_d;
      tick_q <= step;
      mode_q <= mode;
      y_q    <= y_d;
    end
  end
  assign y    = y_q;
  assign idx  = idx_q;
  assign tick = tick_q;
endmodule
